// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier for signed operands
// Ports: clk, rst (async, active-high), start, multiplicand[N], multiplier[N]
//        -> product[2N] (registered, held), done (1-cycle pulse), busy, shift_en
// Option: define BOOTH_ZERO_SKIP_EN to finish a zero-operand request straight
//         from IDLE with product 0 and no iterations.
module booth_seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           done,
  output logic           busy,
  output logic           shift_en
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [N:0]    a_q, a_d, m_q, m_d, sum;
  logic [N-1:0]  q_q, q_d;
  logic          q1_q, q1_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*N-1:0] product_q, product_d;
  // A and M carry one guard bit so that negating M = -2^(N-1) cannot overflow.
  assign sum = ({q_q[0], q1_q} == 2'b01) ? a_q + m_q :
               ({q_q[0], q1_q} == 2'b10) ? a_q - m_q : a_q;
  // RUN holds one extra cycle at count 0 to register the result; no shift then.
  assign shift_en = (state_q == RUN) && (count_q != '0);
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign product  = product_q;
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
        if (multiplicand == '0 || multiplier == '0) begin
          product_d = '0;
          state_d   = DONE;
        end else begin
          m_d     = {multiplicand[N-1], multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = CW'(N);
          state_d = RUN;
        end
`else
        m_d     = {multiplicand[N-1], multiplicand};
        q_d     = multiplier;
        a_d     = '0;
        q1_d    = 1'b0;
        count_d = CW'(N);
        state_d = RUN;
`endif
      end
      RUN: if (count_q != '0) begin
        a_d     = {sum[N], sum[N:1]};
        q_d     = {sum[0], q_q[N-1:1]};
        q1_d    = q_q[0];
        count_d = count_q - CW'(1);
      end else begin
        product_d = {a_q[N-1:0], q_q};
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end
endmodule
